// File: rtl/pc_sequencer.sv
// Program counter with fixed-priority next-PC select (jump > branch > +4), stall/step gating,
// a sticky HALTED state and a saturating advance counter. Optional exception entry: PC_SEQ_EXC_EN.
//
// state  | meaning
// RUN    | PC advances whenever step and pc_write are high and no HALT is decoded
// HALTED | HALT retired; everything but reset is ignored
module pc_sequencer #(
   parameter int unsigned                SIZE_ADDR_PC = 32,
   parameter logic [SIZE_ADDR_PC-1:0]    RESET_VECTOR = '0,
   parameter int unsigned                COUNT_WIDTH  = 32,
   parameter logic [SIZE_ADDR_PC-1:0]    EXC_VECTOR   = SIZE_ADDR_PC'(32'h0000_0080)
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_step,
   input  logic                    i_pc_write,
   input  logic                    i_branch_taken,
   input  logic [SIZE_ADDR_PC-1:0] i_branch_addr,
   input  logic                    i_jump,
   input  logic [SIZE_ADDR_PC-1:0] i_jump_addr,
   input  logic                    i_halt,
`ifdef PC_SEQ_EXC_EN
   input  logic                    i_exception,
`endif
   output logic [SIZE_ADDR_PC-1:0] o_pc,
   output logic [SIZE_ADDR_PC-1:0] o_pc_4,
   output logic [SIZE_ADDR_PC-1:0] o_pc_8,
   output logic                    o_halted,
   output logic [COUNT_WIDTH-1:0]  o_inst_count
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t                  state;
   logic                    adv;
   logic                    halt_req;
   logic [SIZE_ADDR_PC-1:0] pc_target;

   if (SIZE_ADDR_PC < 8 || RESET_VECTOR[1:0] != 2'b00 || EXC_VECTOR[1:0] != 2'b00) begin : g_bad_cfg
      $error("pc_sequencer: SIZE_ADDR_PC must be >= 8 and vectors word aligned");
   end

   assign o_pc_4 = o_pc + SIZE_ADDR_PC'(4);
   assign o_pc_8 = o_pc + SIZE_ADDR_PC'(8);

   // HALT is honoured even during a stall: the instruction is already decoded
   assign halt_req = (state == RUN) && i_step && i_halt;
   assign adv      = (state == RUN) && i_step && i_pc_write && !i_halt;

   always_comb begin
      pc_target = o_pc_4;
      if (i_jump) begin
         pc_target = {i_jump_addr[SIZE_ADDR_PC-1:2], 2'b00};
      end else if (i_branch_taken) begin
         pc_target = {i_branch_addr[SIZE_ADDR_PC-1:2], 2'b00};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= RUN;
         o_pc         <= RESET_VECTOR;
         o_halted     <= 1'b0;
         o_inst_count <= '0;
      end else begin
`ifdef PC_SEQ_EXC_EN
         // exception entry preempts everything in RUN, including a same-cycle HALT
         if ((state == RUN) && i_exception) begin
            o_pc <= EXC_VECTOR;
         end else
`endif
         begin
            if (adv) begin
               o_pc <= pc_target;
               if (o_inst_count != '1) begin
                  o_inst_count <= o_inst_count + COUNT_WIDTH'(1);
               end
            end
            if (halt_req) begin
               state    <= HALTED;
               o_halted <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter unit for the MIPS pipeline front end; successor to the single-source PC register.
- Holds the fetch address and selects the next PC internally from sequential, branch and jump sources by fixed priority.
- Supports debug single-step gating, pipeline stall and a latched HALT state.
- Counts retired fetch advances for the debug unit.

Parameters:
SIZE_ADDR_PC, 32, PC/address width in bits (min 8).
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
COUNT_WIDTH, 32, width of the advance counter.
EXC_VECTOR, 32'h0000_0080, exception entry address (used only with PC_SEQ_EXC_EN).

Ports:
i_clk  in  1  system clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_step  in  1  step enable from debug unit; 1 = run this cycle (tie 1 for continuous mode).
i_pc_write  in  1  hazard-unit write enable; 0 = stall.
i_branch_taken  in  1  branch resolved taken.
i_branch_addr  in  SIZE_ADDR_PC  branch target.
i_jump  in  1  jump / jump-register request.
i_jump_addr  in  SIZE_ADDR_PC  jump target.
i_halt  in  1  HALT instruction decoded at current PC.
o_pc  out  SIZE_ADDR_PC  current fetch address (registered).
o_pc_4  out  SIZE_ADDR_PC  o_pc + 4, combinational, modulo 2^SIZE_ADDR_PC.
o_pc_8  out  SIZE_ADDR_PC  o_pc + 8, combinational, modulo 2^SIZE_ADDR_PC.
o_halted  out  1  1 while in HALTED state (registered).
o_inst_count  out  COUNT_WIDTH  number of PC advances since reset (registered).

Behaviour:
- Clock and reset: single clock i_clk; i_reset is synchronous and active-high.
- Reset (sampled at rising edge), overriding all other inputs:
  - o_pc = RESET_VECTOR
  - o_halted = 0
  - o_inst_count = 0
  - state = RUN
- States: RUN, HALTED. Transitions:
  - RUN -> HALTED when i_step=1 and i_halt=1.
  - HALTED -> RUN only via reset.
- adv = (state==RUN) & i_step & i_pc_write & ~i_halt.
- Next PC when adv=1, by priority:
  1. i_jump=1: i_jump_addr
  2. i_branch_taken=1: i_branch_addr
  3. otherwise: o_pc + 4
- Word alignment: loaded targets have bits [1:0] forced to 0 before registering.
- Wrap: sequential increment wraps modulo 2^SIZE_ADDR_PC with no flag.
- Latency: one cycle from input to o_pc; o_pc_4 and o_pc_8 follow o_pc in the same cycle.
- adv=0 (stall, step low, or HALTED): o_pc holds; o_inst_count holds.
- HALT:
  - On the cycle i_step=1 and i_halt=1, the PC does not advance, even if jump or branch is asserted (halt wins).
  - o_halted rises on the next edge.
  - In HALTED, all inputs except reset are ignored.
- Halt and stall: i_halt with i_pc_write=0 and i_step=1 still enters HALTED, because the HALT instruction is already decoded.
- o_inst_count:
  - +1 on every adv=1 cycle.
  - Saturates at 2^COUNT_WIDTH-1; does not wrap.
- Reset mid-stall or mid-HALT: the reset values above apply on that edge; the PC runs from the next cycle if adv=1.
- Inputs are undefined while i_reset=1 and must not propagate X into state.

Optional Feature:
Macro PC_SEQ_EXC_EN.
- Defined:
  - Adds port i_exception (in, 1).
  - When state==RUN and i_exception=1, next o_pc = EXC_VECTOR, regardless of i_step, i_pc_write, i_jump, i_branch_taken or i_halt.
  - Exception has top priority.
  - o_inst_count does not increment on the exception load.
  - In HALTED, i_exception is ignored.
- Undefined: port absent; EXC_VECTOR unused; behaviour as above.

Test Plan:
1. Reset, then i_step=1 and i_pc_write=1 for 4 cycles -> o_pc 0,4,8,12,16; o_pc_4/o_pc_8 = 20/24 at the end; o_inst_count=4.
2. At o_pc=8, set i_pc_write=0 for 3 cycles -> o_pc stays 8 and count frozen; release -> o_pc=12 next cycle.
3. Same cycle: i_jump=1 with 0x100, i_branch_taken=1 with 0x200 -> o_pc=0x100. Then branch only with 0x203 -> o_pc=0x200 (aligned).
4. i_step toggled 1,0,0,1 from o_pc=0 -> o_pc 4,4,4,8; i_halt=1 with i_jump=1 at o_pc=8 -> o_pc stays 8, o_halted=1; further steps leave o_pc=8; i_reset=1 -> o_pc=0, o_halted=0.
5. SIZE_ADDR_PC=8, run from 0xF8 -> o_pc 0xFC, then 0x00 (wrap); COUNT_WIDTH=3 -> count saturates at 7.
6. With PC_SEQ_EXC_EN, i_exception=1 during a stall at o_pc=0x40 -> o_pc=0x80 next cycle, count unchanged.
